// File: rtl/digit_serial_adder_if.sv
// Valid/ready operand and result channels of the digit-serial adder.
// Port ovf is present only when DSA_OVF_EN is defined.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef DSA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef DSA_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef DSA_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock behind valid/ready.
// Define DSA_OVF_EN to add the registered signed-overflow output ovf.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  digit_serial_adder_if.slave bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LsbW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IdxW-1:0]    idx_q, idx_d;
`ifdef DSA_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [LsbW-1:0]    lsb;
  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [DIGIT:0]     dig_sum;

  always_comb begin
    lsb     = LsbW'(32'(idx_q) * DIGIT);
    a_dig   = a_q[lsb +: DIGIT];
    b_dig   = b_q[lsb +: DIGIT];
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef DSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[lsb +: DIGIT] = dig_sum[DIGIT-1:0];
        carry_d             = dig_sum[DIGIT];
        idx_d               = idx_q + IdxW'(1);
        if (idx_q == IdxW'(N - 1)) begin
          cout_d  = dig_sum[DIGIT];
`ifdef DSA_OVF_EN
          // Sign bits of the top digit are the operand/sum MSBs.
          ovf_d   = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) &&
                    (dig_sum[DIGIT-1] != a_dig[DIGIT-1]);
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef DSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef DSA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef DSA_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule
